// File: rtl/sync_tdp_ram.sv
// Two-port byte-lane RAM with write-collision merge, selectable
// read-during-write behaviour and a post-reset zeroing sweep.
module sync_tdp_ram #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int COLL_PRIORITY = 0,
  parameter int RDW_MODE      = 0,
  localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen_0,
  input  logic                  cen_1,
  input  logic                  wen_0,
  input  logic                  wen_1,
  input  logic [NB-1:0]         be_0,
  input  logic [NB-1:0]         be_1,
  input  logic [ADDR_WIDTH-1:0] a_0,
  input  logic [ADDR_WIDTH-1:0] a_1,
  input  logic [DATA_WIDTH-1:0] d_0,
  input  logic [DATA_WIDTH-1:0] d_1,
  output logic [DATA_WIDTH-1:0] q_0,
  output logic [DATA_WIDTH-1:0] q_1,
  output logic                  ready,
  output logic                  coll
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic HI = (COLL_PRIORITY != 0);
  localparam logic LO = !HI;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic {INIT, RUN} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                      state_q, state_d;
  logic [CW-1:0]               clr_q, clr_d;
  logic                        coll_q, coll_d;
  logic [1:0][DATA_WIDTH-1:0]  p1_q, p1_d;

  logic                        run;
  logic [1:0]                  wr, rd;
  logic [1:0][ADDR_WIDTH-1:0]  adr;
  logic [1:0][DATA_WIDTH-1:0]  dat, msk, nw;

  assign run = (state_q == RUN);
  assign wr  = {run & ~cen_1 & ~wen_1, run & ~cen_0 & ~wen_0};
  assign rd  = {run & ~cen_1 & wen_1, run & ~cen_0 & wen_0};
  assign adr = {a_1, a_0};
  assign dat = {d_1, d_0};

  always_comb begin
    msk = '0;
    for (int i = 0; i < NB; i++) begin
      msk[0][i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr[0] & be_0[i]}};
      msk[1][i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr[1] & be_1[i]}};
    end
  end

  // Post-write word at each port's address: loser lanes first, winner on top.
  always_comb begin
    nw = '0;
    for (int p = 0; p < 2; p++) begin
      nw[p] = mem[adr[p]];
      if (adr[LO] == adr[p])
        nw[p] = (nw[p] & ~msk[LO]) | (dat[LO] & msk[LO]);
      if (adr[HI] == adr[p])
        nw[p] = (nw[p] & ~msk[HI]) | (dat[HI] & msk[HI]);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      if (wr[0]) mem[a_0] <= nw[0];
      if (wr[1]) mem[a_1] <= nw[1];
    end
  end

  always_comb begin
    p1_d = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd[p])
        p1_d[p] = (RDW_MODE != 0) ? nw[p] : mem[adr[p]];
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    coll_d  = wr[0] & wr[1] & (a_0 == a_1) & (|(be_0 & be_1));
    unique case (state_q)
      INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      clr_q   <= '0;
      coll_q  <= 1'b0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      coll_q  <= coll_d;
      p1_q    <= p1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_l2
    logic [1:0][DATA_WIDTH-1:0] p2_q, p2_d;
    always_comb p2_d = p1_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) p2_q <= '0;
      else     p2_q <= p2_d;
    end
    assign q_0 = p2_q[0];
    assign q_1 = p2_q[1];
  end else begin : g_l1
    assign q_0 = p1_q[0];
    assign q_1 = p1_q[1];
  end

  assign ready = run;
  assign coll  = coll_q;

endmodule

// File: tb/tb_sync_tdp_ram.sv
// Bench driving two differently-parameterised RAMs with the same
// stimulus and checking both against a word-level array model.
module tb_sync_tdp_ram;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen_0, cen_1, wen_0, wen_1;
  logic [NB-1:0] be_0, be_1;
  logic [AW-1:0] a_0, a_1;
  logic [DW-1:0] d_0, d_1;
  logic [DW-1:0] qa_0, qa_1, qb_0, qb_1;
  logic          rdy_a, rdy_b, col_a, col_b;

  always #5 clk = ~clk;

  sync_tdp_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .COLL_PRIORITY(0), .RDW_MODE(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .cen_0(cen_0), .cen_1(cen_1), .wen_0(wen_0), .wen_1(wen_1),
    .be_0(be_0), .be_1(be_1), .a_0(a_0), .a_1(a_1),
    .d_0(d_0), .d_1(d_1), .q_0(qa_0), .q_1(qa_1),
    .ready(rdy_a), .coll(col_a)
  );

  sync_tdp_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .COLL_PRIORITY(1), .RDW_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cen_0(cen_0), .cen_1(cen_1), .wen_0(wen_0), .wen_1(wen_1),
    .be_0(be_0), .be_1(be_1), .a_0(a_0), .a_1(a_1),
    .d_0(d_0), .d_1(d_1), .q_0(qb_0), .q_1(qb_1),
    .ready(rdy_b), .coll(col_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance 0: latency 1, port 0 wins, old data.
  // Instance 1: latency 2, port 1 wins, new data.
  logic [DW-1:0] mm   [2][D];
  logic [DW-1:0] s1   [2][2];
  logic [DW-1:0] eq   [2][2];
  logic          ecol [2];
  int            icnt;
  logic          mready;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ecol[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        s1[k][p] = '0;
        eq[k][p] = '0;
      end
    end
    icnt   = 0;
    mready = 1'b0;
  endtask

  task automatic model_edge();
    logic          w [2];
    logic          r [2];
    logic [AW-1:0] aa [2];
    logic [DW-1:0] dd [2];
    logic [NB-1:0] bb [2];
    logic [DW-1:0] old_v [2];
    logic [DW-1:0] rv [2];
    int            order [2];
    w[0] = !cen_0 && !wen_0;  r[0] = !cen_0 && wen_0;
    w[1] = !cen_1 && !wen_1;  r[1] = !cen_1 && wen_1;
    aa[0] = a_0;  aa[1] = a_1;
    dd[0] = d_0;  dd[1] = d_1;
    bb[0] = be_0; bb[1] = be_1;
    for (int k = 0; k < 2; k++) begin
      rv[0] = '0;
      rv[1] = '0;
      ecol[k] = 1'b0;
      if (mready) begin
        for (int p = 0; p < 2; p++) old_v[p] = mm[k][aa[p]];
        order[0] = 1 - k;
        order[1] = k;
        for (int o = 0; o < 2; o++) begin
          int p;
          p = order[o];
          if (w[p])
            for (int i = 0; i < NB; i++)
              if (bb[p][i]) mm[k][aa[p]][8*i +: 8] = dd[p][8*i +: 8];
        end
        for (int p = 0; p < 2; p++)
          if (r[p]) rv[p] = (k == 1) ? mm[k][aa[p]] : old_v[p];
        ecol[k] = w[0] && w[1] && (aa[0] == aa[1]) && ((bb[0] & bb[1]) != 0);
      end
      for (int p = 0; p < 2; p++) begin
        if (k == 0) eq[k][p] = rv[p];
        else begin
          eq[k][p] = s1[k][p];
          s1[k][p] = rv[p];
        end
      end
    end
    if (!mready) begin
      icnt++;
      if (icnt == D) begin
        mready = 1'b1;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < D; i++) mm[k][i] = '0;
      end
    end
  endtask

  task automatic check_all();
    chk("qa_0", qa_0, eq[0][0]);
    chk("qa_1", qa_1, eq[0][1]);
    chk("qb_0", qb_0, eq[1][0]);
    chk("qb_1", qb_1, eq[1][1]);
    chk("coll_a", col_a, ecol[0]);
    chk("coll_b", col_b, ecol[1]);
    chk("ready_a", rdy_a, mready);
    chk("ready_b", rdy_b, mready);
  endtask

  task automatic cyc(input logic c0, input logic w0, input logic [NB-1:0] b0,
                     input logic [AW-1:0] ad0, input logic [DW-1:0] dt0,
                     input logic c1, input logic w1, input logic [NB-1:0] b1,
                     input logic [AW-1:0] ad1, input logic [DW-1:0] dt1);
    cen_0 = c0; wen_0 = w0; be_0 = b0; a_0 = ad0; d_0 = dt0;
    cen_1 = c1; wen_1 = w1; be_1 = b1; a_1 = ad1; d_1 = dt1;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1, 1, '0, '0, '0, 1, 1, '0, '0, '0);
  endtask

  task automatic rnd_cyc(input int amax);
    cyc($urandom_range(0, 1), $urandom_range(0, 1), NB'($urandom),
        AW'($urandom_range(0, amax)), $urandom,
        $urandom_range(0, 1), $urandom_range(0, 1), NB'($urandom),
        AW'($urandom_range(0, amax)), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_qa_0", qa_0, '0);
    chk("rst_qb_0", qb_0, '0);
    chk("rst_qb_1", qb_1, '0);
    chk("rst_rdy", rdy_a, 1'b0);
    chk("rst_coll", col_a, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cen_0 = 1; wen_0 = 1; be_0 = '0; a_0 = '0; d_0 = '0;
    cen_1 = 1; wen_1 = 1; be_1 = '0; a_1 = '0; d_1 = '0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < D; i++) begin
      rnd_cyc(D - 1);
      chk("init_ready", rdy_a, (i == D - 1));
    end

    for (int i = 0; i < D; i++)
      cyc(0, 1, '0, AW'(i), '0, 0, 1, '0, AW'(D - 1 - i), '0);
    idle();

    cyc(0, 0, 4'b1111, 4'd3, 32'hAABBCCDD, 1, 1, '0, '0, '0);
    cyc(1, 1, '0, '0, '0, 0, 0, 4'b0101, 4'd3, 32'h11223344);
    cyc(0, 1, '0, 4'd3, '0, 1, 1, '0, '0, '0);
    chk("lane_a", qa_0, 32'hAA22CC44);
    idle();
    chk("lane_b", qb_0, 32'hAA22CC44);
    chk("zero_a", qa_0, '0);

    cyc(0, 0, 4'b0011, 4'd5, 32'h000000FF, 0, 0, 4'b1111, 4'd5, 32'h12345678);
    chk("coll_hi", col_a, 1'b1);
    cyc(0, 1, '0, 4'd5, '0, 1, 1, '0, '0, '0);
    chk("coll_lo", col_a, 1'b0);
    chk("coll_a", qa_0, 32'h123400FF);
    idle();
    chk("coll_b", qb_0, 32'h12345678);

    cyc(0, 0, 4'b1111, 4'd7, 32'h1, 1, 1, '0, '0, '0);
    cyc(0, 0, 4'b1111, 4'd7, 32'h2, 0, 1, '0, 4'd7, '0);
    chk("rdw_old", qa_1, 32'h1);
    idle();
    chk("rdw_new", qb_1, 32'h2);

    cyc(0, 1, '0, 4'd3, '0, 1, 1, '0, '0, '0);
    cyc(1, 1, '0, '0, '0, 1, 1, '0, '0, '0);
    chk("lat2_d0", qb_0, 32'hAA22CC44);
    cyc(0, 1, '0, 4'd7, '0, 1, 1, '0, '0, '0);
    chk("lat2_z", qb_0, '0);
    idle();
    chk("lat2_d1", qb_0, 32'h2);

    for (int i = 0; i < 400; i++) rnd_cyc((i < 200) ? 3 : D - 1);

    cyc(0, 0, 4'b1111, 4'd3, 32'hDEADBEEF, 1, 1, '0, '0, '0);
    cyc(0, 1, '0, 4'd3, '0, 1, 1, '0, '0, '0);
    chk("pre_rst", qa_0, 32'hDEADBEEF);
    do_reset();
    for (int i = 0; i < D; i++) rnd_cyc(D - 1);
    chk("re_ready", rdy_b, 1'b1);
    cyc(0, 1, '0, 4'd3, '0, 0, 1, '0, 4'd7, '0);
    chk("re_zero", qa_0, '0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
